fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, byte address of the first fetched instruction.
REQ-002 SHALL have parameter PC_INC, default 4, byte increment between sequential fetches.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset: asynchronous and active-low.
REQ-005 SHALL have port stall, input, 1, hold PC and IF/ID contents this cycle (hazard unit).
REQ-006 SHALL have port br_taken, input, 1, branch resolved taken in ID (bez or bnez condition met).
REQ-007 SHALL have port br_target, input, [0:15], branch target byte address, zero-extended to 32 bits.
REQ-008 SHALL have port imem_addr, output, [0:31], instruction memory read address.
REQ-009 SHALL have port imem_rdEn, output, 1, instruction memory read enable.
REQ-010 SHALL have port imem_data, input, [0:31], read data, valid one cycle after the address is presented.
REQ-011 SHALL have port IF_ID_inst, output, [0:31], instruction word presented to decode.
REQ-012 SHALL have port IF_ID_pc, output, [0:31], byte address of IF_ID_inst.
REQ-013 SHALL have port IF_ID_valid, output, 1, IF_ID_inst is a real fetched instruction.

Function
REQ-014 SHALL hold pc, the address currently in flight; imem_addr = pc at all times.
REQ-015 SHALL implement FSM states BOOT, RUN, HOLD and REDIRECT.
REQ-016 BOOT SHALL be entered on reset, last exactly one cycle, issue the read of RESET_PC, present VNOP (6'b111100, remaining bits 0) with IF_ID_valid=0, and go to RUN.
REQ-017 RUN, no stall, no br_taken SHALL capture imem_data into IF_ID_inst, set IF_ID_pc to the previous pc, set IF_ID_valid=1, and advance pc += PC_INC (mod 2^32 wrap).
REQ-018 On stall=1 in RUN, SHALL freeze pc and all IF_ID outputs, save the returning imem_data in a one-entry replay register, deassert imem_rdEn, and go to HOLD.
REQ-019 HOLD SHALL keep everything frozen while stall=1; on stall=0 it SHALL load IF_ID outputs from the replay register, advance pc, reassert imem_rdEn, and go to RUN with no lost or duplicated instruction.
REQ-020 br_taken=1 SHALL take priority over stall: pc is loaded with the zero-extended br_target, IF_ID becomes VNOP with valid=0, the replay register is cleared, and the FSM goes to REDIRECT.
REQ-021 REDIRECT SHALL last one cycle, discarding the wrong-path imem_data, keeping IF_ID as VNOP/valid=0, advancing pc += PC_INC, then going to RUN.
REQ-022 A br_taken asserted while in REDIRECT SHALL restart the redirect to the new target.
REQ-023 Branch penalty SHALL be exactly two bubbles: one from the flush and one from the memory latency.
REQ-024 imem_rdEn SHALL be 1 in BOOT, RUN and REDIRECT, and 0 in HOLD.

Reset
REQ-025 rst_n=0 SHALL asynchronously force pc=RESET_PC, FSM=BOOT, IF_ID_inst=VNOP word, IF_ID_pc=0, IF_ID_valid=0, replay register empty, and perf counters 0.
REQ-026 Reset asserted mid-stall or mid-redirect SHALL abandon all in-flight state; fetch restarts at RESET_PC on the first clk edge after rst_n rises.

Configuration
REQ-027 Macro FETCH_PERF_CNT_EN SHALL gate the performance counters; with it defined, the block adds outputs perf_fetch_cnt [0:31] and perf_flush_cnt [0:31].
REQ-028 perf_fetch_cnt SHALL increment on every IF_ID_valid=1 load; perf_flush_cnt SHALL increment on every cycle with br_taken=1; both wrap at 2^32.
REQ-029 Without FETCH_PERF_CNT_EN, the counters and their ports SHALL be absent, with no other change in behaviour.

Structure
REQ-030 The shared package SHALL hold the VNOP opcode, the VNOP instruction word, the FSM state encoding and the instruction/PC widths; decode uses the same opcode constants.
REQ-031 The replay register plus its valid bit SHALL be a sub-module, fetch_replay_buf; everything else is flat.

Verification
REQ-032 Reset release, imem returning word = address: IF_ID_pc SHALL read 0, 4, 8, 12 on consecutive cycles after one BOOT bubble.
REQ-033 stall held 3 cycles while IF_ID_pc=8: IF_ID SHALL hold 8 for 3 cycles, then show 12 with no duplicate and no skip.
REQ-034 br_taken with br_target=16'h0040 while IF_ID_pc=8: SHALL produce two VNOP/valid=0 cycles, then IF_ID_pc=0x40, 0x44.
REQ-035 br_taken and stall asserted in the same cycle: the redirect SHALL win, with the same sequence as REQ-034.
REQ-036 pc at 32'hFFFF_FFFC: the next IF_ID_pc SHALL be 0.
REQ-037 rst_n pulsed low during HOLD: outputs SHALL reset immediately; refetch restarts at RESET_PC. With FETCH_PERF_CNT_EN: after 10 fetches and 1 branch, the counters SHALL read 10 and 1.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared fetch/decode definitions: instruction and PC widths, VNOP encoding,
// fetch FSM states and the IF/ID payload.
package fetch_stage_pkg;

    localparam int unsigned INST_W   = 32;
    localparam int unsigned PC_W     = 32;
    localparam int unsigned OPC_W    = 6;
    localparam int unsigned BR_TGT_W = 16;

    localparam logic [OPC_W-1:0]  OPC_VNOP  = 6'b111100;
    localparam logic [INST_W-1:0] VNOP_WORD = {OPC_VNOP, {(INST_W-OPC_W){1'b0}}};

    typedef enum logic [1:0] {
        BOOT     = 2'd0,
        RUN      = 2'd1,
        HOLD     = 2'd2,
        REDIRECT = 2'd3
    } fetch_state_t;

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [PC_W-1:0]   pc;
        logic              valid;
    } if_id_t;

    localparam if_id_t IF_ID_BUBBLE = '{inst: VNOP_WORD, pc: '0, valid: 1'b0};

endpackage

// File: rtl/fetch_replay_buf.sv
// One-entry replay register holding the instruction word that returned from
// imem in the cycle a stall froze the fetch pipe.
module fetch_replay_buf
    import fetch_stage_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic              i_clear,
    input  logic [INST_W-1:0] i_data,
    output logic [INST_W-1:0] o_data,
    output logic              o_valid
);

    logic [INST_W-1:0] r_data;
    logic              r_valid;

    // Clear wins over load so a redirect always empties the entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data  <= VNOP_WORD;
            r_valid <= 1'b0;
        end else if (i_clear) begin
            r_data  <= VNOP_WORD;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_data  <= i_data;
            r_valid <= 1'b1;
        end
    end

    assign o_data  = r_data;
    assign o_valid = r_valid;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC sequencing, stall replay and branch redirect.
// Optional performance counters are built when FETCH_PERF_CNT_EN is defined.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned     PC_INC   = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                stall,
    input  logic                br_taken,
    input  logic [BR_TGT_W-1:0] br_target,
    output logic [PC_W-1:0]     imem_addr,
    output logic                imem_rdEn,
    input  logic [INST_W-1:0]   imem_data,
    output logic [INST_W-1:0]   IF_ID_inst,
    output logic [PC_W-1:0]     IF_ID_pc,
    output logic                IF_ID_valid
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]         perf_fetch_cnt,
    output logic [31:0]         perf_flush_cnt
`endif
);

    fetch_state_t      r_state;
    fetch_state_t      w_state_nxt;
    logic [PC_W-1:0]   r_pc;
    logic [PC_W-1:0]   w_pc_nxt;
    logic [PC_W-1:0]   w_pc_inc;
    logic [PC_W-1:0]   w_pc_prev;
    if_id_t            r_ifid;
    if_id_t            w_ifid_nxt;
    logic              r_rden;
    logic              w_rpl_load;
    logic              w_rpl_clear;
    logic [INST_W-1:0] w_rpl_data;
    logic              w_rpl_valid;

    // The word arriving on imem_data always belongs to pc - PC_INC.
    assign w_pc_inc  = r_pc + PC_W'(PC_INC);
    assign w_pc_prev = r_pc - PC_W'(PC_INC);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= BOOT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_ifid_nxt  = r_ifid;
        w_rpl_load  = 1'b0;
        w_rpl_clear = 1'b0;
        if (br_taken) begin
            w_state_nxt = REDIRECT;
            w_pc_nxt    = {{(PC_W-BR_TGT_W){1'b0}}, br_target};
            w_ifid_nxt  = IF_ID_BUBBLE;
            w_rpl_clear = 1'b1;
        end else begin
            case (r_state)
                BOOT: begin
                    w_pc_nxt    = w_pc_inc;
                    w_ifid_nxt  = IF_ID_BUBBLE;
                    w_state_nxt = RUN;
                end
                RUN: begin
                    if (stall) begin
                        w_rpl_load  = 1'b1;
                        w_state_nxt = HOLD;
                    end else begin
                        w_pc_nxt   = w_pc_inc;
                        w_ifid_nxt = '{inst: imem_data, pc: w_pc_prev, valid: 1'b1};
                    end
                end
                HOLD: begin
                    // imem kept its last output while rdEn was low, so the
                    // word for the frozen pc is still on imem_data next cycle.
                    if (!stall) begin
                        w_pc_nxt    = w_pc_inc;
                        w_ifid_nxt  = '{inst: w_rpl_data, pc: w_pc_prev, valid: w_rpl_valid};
                        w_rpl_clear = 1'b1;
                        w_state_nxt = RUN;
                    end
                end
                REDIRECT: begin
                    w_pc_nxt    = w_pc_inc;
                    w_ifid_nxt  = IF_ID_BUBBLE;
                    w_state_nxt = RUN;
                end
                default: begin
                    w_state_nxt = BOOT;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc   <= RESET_PC;
            r_ifid <= IF_ID_BUBBLE;
            r_rden <= 1'b1;
        end else begin
            r_pc   <= w_pc_nxt;
            r_ifid <= w_ifid_nxt;
            r_rden <= (w_state_nxt != HOLD);
        end
    end

    fetch_replay_buf u_replay (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_rpl_load),
        .i_clear (w_rpl_clear),
        .i_data  (imem_data),
        .o_data  (w_rpl_data),
        .o_valid (w_rpl_valid)
    );

    assign imem_addr   = r_pc;
    assign imem_rdEn   = r_rden;
    assign IF_ID_inst  = r_ifid.inst;
    assign IF_ID_pc    = r_ifid.pc;
    assign IF_ID_valid = r_ifid.valid;

`ifdef FETCH_PERF_CNT_EN
    logic        w_fetch_load;
    logic [31:0] r_perf_fetch;
    logic [31:0] r_perf_flush;

    // Mirrors the valid IF/ID loads of the next-state logic.
    assign w_fetch_load = !br_taken && !stall &&
                          ((r_state == RUN) || ((r_state == HOLD) && w_rpl_valid));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_fetch <= 32'd0;
            r_perf_flush <= 32'd0;
        end else begin
            if (w_fetch_load) begin
                r_perf_fetch <= r_perf_fetch + 32'd1;
            end
            if (br_taken) begin
                r_perf_flush <= r_perf_flush + 32'd1;
            end
        end
    end

    assign perf_fetch_cnt = r_perf_fetch;
    assign perf_flush_cnt = r_perf_flush;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed, table-driven bench for fetch_stage with an imem model whose read
// data equals the address and which holds its output while rdEn is low.
module tb_fetch_stage;

    localparam logic [31:0] VNOP = 32'hF000_0000;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        br_taken;
    logic [15:0] br_target;
    logic [31:0] imem_addr;
    logic        imem_rdEn;
    logic [31:0] imem_data;
    logic [31:0] IF_ID_inst;
    logic [31:0] IF_ID_pc;
    logic        IF_ID_valid;

    logic        wr_stall;
    logic        wr_br;
    logic [15:0] wr_tgt;
    logic [31:0] wr_addr;
    logic        wr_rden;
    logic [31:0] wr_data;
    logic [31:0] wr_inst;
    logic [31:0] wr_pc;
    logic        wr_valid;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_flush_cnt;
    logic [31:0] wr_perf_fetch;
    logic [31:0] wr_perf_flush;
`endif

    int checks   = 0;
    int failures = 0;

    fetch_stage #(.RESET_PC(32'h0000_0000), .PC_INC(4)) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (stall),
        .br_taken    (br_taken),
        .br_target   (br_target),
        .imem_addr   (imem_addr),
        .imem_rdEn   (imem_rdEn),
        .imem_data   (imem_data),
        .IF_ID_inst  (IF_ID_inst),
        .IF_ID_pc    (IF_ID_pc),
        .IF_ID_valid (IF_ID_valid)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_flush_cnt (perf_flush_cnt)
`endif
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFF8), .PC_INC(4)) u_wrap (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (wr_stall),
        .br_taken    (wr_br),
        .br_target   (wr_tgt),
        .imem_addr   (wr_addr),
        .imem_rdEn   (wr_rden),
        .imem_data   (wr_data),
        .IF_ID_inst  (wr_inst),
        .IF_ID_pc    (wr_pc),
        .IF_ID_valid (wr_valid)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetch_cnt (wr_perf_fetch),
        .perf_flush_cnt (wr_perf_flush)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // imem: one-cycle latency, data = address, output held when not enabled
    initial begin
        imem_data = 32'd0;
        wr_data   = 32'd0;
    end
    always @(posedge clk) begin
        if (imem_rdEn) imem_data <= imem_addr;
        if (wr_rden)   wr_data   <= wr_addr;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        rst;
        logic        stl;
        logic        br;
        logic [15:0] tgt;
        logic        ev;
        logic [31:0] epc;
        logic [31:0] eaddr;
        logic        erd;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic rst, input logic stl, input logic br,
                                input logic [15:0] tgt, input logic ev,
                                input logic [31:0] epc, input logic [31:0] eaddr,
                                input logic erd);
        vec_t v;
        v.rst = rst; v.stl = stl; v.br = br; v.tgt = tgt;
        v.ev = ev; v.epc = epc; v.eaddr = eaddr; v.erd = erd;
        vecs.push_back(v);
    endfunction

    // Reset cycle, BOOT bubble, then fetches of 0, 4, 8.
    function automatic void add_start(input logic with_reset);
        if (with_reset) add(1, 0, 0, 16'h0, 0, 32'h0, 32'h0, 1);
        add(0, 0, 0, 16'h0, 0, 32'h0, 32'h4,  1);
        add(0, 0, 0, 16'h0, 1, 32'h0, 32'h8,  1);
        add(0, 0, 0, 16'h0, 1, 32'h4, 32'hC,  1);
        add(0, 0, 0, 16'h0, 1, 32'h8, 32'h10, 1);
    endfunction

    task automatic chk_ifid(input string tag, input logic ev, input logic [31:0] epc);
        chk({tag, " valid"}, 32'(IF_ID_valid), 32'(ev));
        chk({tag, " inst"}, IF_ID_inst, ev ? epc : VNOP);
        if (ev) chk({tag, " pc"}, IF_ID_pc, epc);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; br_taken = 1'b0; br_target = 16'h0;
        wr_stall = 1'b0; wr_br = 1'b0; wr_tgt = 16'h0;

        // sequential fetch, then a 3-cycle stall while IF_ID_pc = 8
        add_start(0);
        add(0, 1, 0, 16'h0, 1, 32'h8,  32'h10, 0);
        add(0, 1, 0, 16'h0, 1, 32'h8,  32'h10, 0);
        add(0, 1, 0, 16'h0, 1, 32'h8,  32'h10, 0);
        add(0, 0, 0, 16'h0, 1, 32'hC,  32'h14, 1);
        add(0, 0, 0, 16'h0, 1, 32'h10, 32'h18, 1);
        add(0, 0, 0, 16'h0, 1, 32'h14, 32'h1C, 1);
        // branch to 0x40 while IF_ID_pc = 8
        add_start(1);
        add(0, 0, 1, 16'h0040, 0, 32'h0,  32'h40, 1);
        add(0, 0, 0, 16'h0,    0, 32'h0,  32'h44, 1);
        add(0, 0, 0, 16'h0,    1, 32'h40, 32'h48, 1);
        add(0, 0, 0, 16'h0,    1, 32'h44, 32'h4C, 1);
        // branch and stall together, redirect restart, branch out of HOLD
        add_start(1);
        add(0, 1, 1, 16'h0040, 0, 32'h0,   32'h40,  1);
        add(0, 0, 0, 16'h0,    0, 32'h0,   32'h44,  1);
        add(0, 0, 0, 16'h0,    1, 32'h40,  32'h48,  1);
        add(0, 0, 0, 16'h0,    1, 32'h44,  32'h4C,  1);
        add(0, 0, 1, 16'h0100, 0, 32'h0,   32'h100, 1);
        add(0, 0, 1, 16'h0200, 0, 32'h0,   32'h200, 1);
        add(0, 0, 0, 16'h0,    0, 32'h0,   32'h204, 1);
        add(0, 0, 0, 16'h0,    1, 32'h200, 32'h208, 1);
        add(0, 0, 0, 16'h0,    1, 32'h204, 32'h20C, 1);
        add(0, 1, 0, 16'h0,    1, 32'h204, 32'h20C, 0);
        add(0, 1, 1, 16'h0080, 0, 32'h0,   32'h80,  1);
        add(0, 0, 0, 16'h0,    0, 32'h0,   32'h84,  1);
        add(0, 0, 0, 16'h0,    1, 32'h80,  32'h88,  1);
        add(0, 0, 0, 16'h0,    1, 32'h84,  32'h8C,  1);

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset valid", 32'(IF_ID_valid), 32'd0);
        chk("reset inst", IF_ID_inst, VNOP);
        chk("reset pc", IF_ID_pc, 32'd0);
        chk("reset addr", imem_addr, 32'd0);
        chk("reset rden", 32'(imem_rdEn), 32'd1);
        chk("reset wrap addr", wr_addr, 32'hFFFF_FFF8);
`ifdef FETCH_PERF_CNT_EN
        chk("reset perf fetch", perf_fetch_cnt, 32'd0);
        chk("reset perf flush", perf_flush_cnt, 32'd0);
`endif

        for (int i = 0; i < vecs.size(); i++) begin
            rst_n     = !vecs[i].rst;
            stall     = vecs[i].stl;
            br_taken  = vecs[i].br;
            br_target = vecs[i].tgt;
            tick();
            chk($sformatf("row%0d valid", i), 32'(IF_ID_valid), 32'(vecs[i].ev));
            chk($sformatf("row%0d inst", i), IF_ID_inst, vecs[i].ev ? vecs[i].epc : VNOP);
            if (vecs[i].ev || vecs[i].rst)
                chk($sformatf("row%0d pc", i), IF_ID_pc, vecs[i].epc);
            chk($sformatf("row%0d addr", i), imem_addr, vecs[i].eaddr);
            chk($sformatf("row%0d rden", i), 32'(imem_rdEn), 32'(vecs[i].erd));
        end
        stall = 1'b0; br_taken = 1'b0; br_target = 16'h0;

        // asynchronous reset in the middle of a HOLD
        stall = 1'b1;
        tick();
        chk("hold rden", 32'(imem_rdEn), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async rst valid", 32'(IF_ID_valid), 32'd0);
        chk("async rst inst", IF_ID_inst, VNOP);
        chk("async rst pc", IF_ID_pc, 32'd0);
        chk("async rst addr", imem_addr, 32'd0);
        chk("async rst rden", 32'(imem_rdEn), 32'd1);
        stall = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        chk_ifid("refetch boot", 1'b0, 32'h0);
        chk("refetch boot addr", imem_addr, 32'h4);
        tick();
        chk_ifid("refetch 0", 1'b1, 32'h0);
        tick();
        chk_ifid("refetch 4", 1'b1, 32'h4);

        // pc wrap at 2^32 on the second instance
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        chk("wrap boot valid", 32'(wr_valid), 32'd0);
        chk("wrap boot addr", wr_addr, 32'hFFFF_FFFC);
        tick();
        chk("wrap pc fff8", wr_pc, 32'hFFFF_FFF8);
        chk("wrap addr 0", wr_addr, 32'h0);
        tick();
        chk("wrap pc fffc", wr_pc, 32'hFFFF_FFFC);
        chk("wrap inst fffc", wr_inst, 32'hFFFF_FFFC);
        tick();
        chk("wrap pc 0", wr_pc, 32'h0);
        chk("wrap valid 0", 32'(wr_valid), 32'd1);

`ifdef FETCH_PERF_CNT_EN
        // 10 fetches and one branch after a fresh reset
        rst_n = 1'b0;
        tick();
        chk("perf rst fetch", perf_fetch_cnt, 32'd0);
        rst_n = 1'b1;
        repeat (11) tick();
        br_taken = 1'b1;
        br_target = 16'h0010;
        tick();
        br_taken = 1'b0;
        chk("perf fetch cnt", perf_fetch_cnt, 32'd10);
        chk("perf flush cnt", perf_flush_cnt, 32'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
